// File: rtl/out_frame_ctrl_pkg.sv
// Shared types and constants for the acceleration output-buffer
// frame controller.
package out_frame_ctrl_pkg;

   localparam int ACC_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      STREAM,
      CLR
   } out_frame_state_t;

endpackage

// File: rtl/out_frame_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at
// the pointer and wraps; pointer moves past the winner on advance.
module rr_arbiter #(
   parameter int NUM_LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_LANES-1:0] req,
   input  logic                 advance,
   output logic [NUM_LANES-1:0] gnt
);

   localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [PW:0] NL = (PW+1)'(NUM_LANES);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_next_ptr;
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_lane;
   logic          w_found;

   always_comb begin
      gnt        = '0;
      w_next_ptr = r_ptr;
      w_found    = 1'b0;
      w_sum      = '0;
      w_lane     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= NL) begin
            w_sum = w_sum - NL;
         end
         w_lane = w_sum[PW-1:0];
         if (!w_found && req[w_lane]) begin
            w_found     = 1'b1;
            gnt[w_lane] = 1'b1;
            if (w_sum == NL - (PW+1)'(1)) begin
               w_next_ptr = '0;
            end else begin
               w_next_ptr = w_lane + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (advance) begin
         r_ptr <= w_next_ptr;
      end
   end

endmodule

// File: rtl/out_frame_ctrl.sv
// Frame controller: arbitrates lane writes into the output buffer,
// tracks written indices, then streams and clears the frame.
module out_frame_ctrl
   import out_frame_ctrl_pkg::*;
#(
   parameter int N         = 256,
   parameter int IDX_BITS  = $clog2(N),
   parameter int NUM_LANES = 4
) (
   input  logic                          CLK_IN,
   input  logic                          RESET_IN,
   input  logic                          START,
   input  logic [NUM_LANES-1:0]          LANE_REQ,
   input  logic [NUM_LANES*IDX_BITS-1:0] LANE_IDX,
   input  logic [NUM_LANES*ACC_W-1:0]    LANE_ACC_X,
   input  logic [NUM_LANES*ACC_W-1:0]    LANE_ACC_Y,
   output logic [NUM_LANES-1:0]          LANE_GNT,
   output logic                          WR_EN,
   output logic [IDX_BITS-1:0]           WR_IDX,
   output logic [ACC_W-1:0]              ACC_X,
   output logic [ACC_W-1:0]              ACC_Y,
   output logic                          FRAME_VALID,
   output logic                          CLEAR,
   input  logic                          DONE,
   output logic                          BUSY,
   output logic                          FRAME_DONE,
   output logic                          ERR
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]     N_CNT = CW'(N);
   localparam logic [IDX_BITS:0] N_IDX = (IDX_BITS+1)'(N);

   out_frame_state_t r_state;
   out_frame_state_t w_next;

   logic [N-1:0]          r_map;
   logic [CW-1:0]         r_count;
   logic                  r_wr_en;
   logic [IDX_BITS-1:0]   r_wr_idx;
   logic [ACC_W-1:0]      r_acc_x;
   logic [ACC_W-1:0]      r_acc_y;
   logic                  r_err;

   logic                  w_arb_en;
   logic [NUM_LANES-1:0]  w_req;
   logic [NUM_LANES-1:0]  w_gnt;
   logic                  w_any_gnt;
   logic [IDX_BITS-1:0]   w_idx;
   logic [ACC_W-1:0]      w_ax;
   logic [ACC_W-1:0]      w_ay;
   logic                  w_in_range;
   logic                  w_bad;

   // No grants once the frame is full or while reset is being applied.
   assign w_arb_en  = RESET_IN && (r_state == COLLECT)
                      && (r_count != N_CNT);
   assign w_req     = LANE_REQ & {NUM_LANES{w_arb_en}};
   assign w_any_gnt = |w_gnt;

   rr_arbiter #(
      .NUM_LANES (NUM_LANES)
   ) u_arb (
      .clk     (CLK_IN),
      .rst_n   (RESET_IN),
      .req     (w_req),
      .advance (w_any_gnt),
      .gnt     (w_gnt)
   );

   assign LANE_GNT = w_gnt;

   always_comb begin
      w_idx = '0;
      w_ax  = '0;
      w_ay  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (w_gnt[i]) begin
            w_idx = LANE_IDX[i*IDX_BITS +: IDX_BITS];
            w_ax  = LANE_ACC_X[i*ACC_W +: ACC_W];
            w_ay  = LANE_ACC_Y[i*ACC_W +: ACC_W];
         end
      end
   end

   assign w_in_range = ({1'b0, w_idx} < N_IDX);
   assign w_bad      = !w_in_range || r_map[w_idx];

   // Rejected grants still consume the lane but leave the buffer untouched.
   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) begin
         r_map    <= '0;
         r_count  <= '0;
         r_wr_en  <= 1'b0;
         r_wr_idx <= '0;
         r_acc_x  <= '0;
         r_acc_y  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (r_state == CLR) begin
            r_map   <= '0;
            r_count <= '0;
         end else if (w_any_gnt) begin
            if (w_bad) begin
               r_err <= 1'b1;
            end else begin
               r_map[w_idx] <= 1'b1;
               r_count      <= r_count + CW'(1);
               r_wr_en      <= 1'b1;
               r_wr_idx     <= w_idx;
               r_acc_x      <= w_ax;
               r_acc_y      <= w_ay;
            end
         end
      end
   end

   assign WR_EN  = r_wr_en;
   assign WR_IDX = r_wr_idx;
   assign ACC_X  = r_acc_x;
   assign ACC_Y  = r_acc_y;
   assign ERR    = r_err;

   always_ff @(posedge CLK_IN) begin
      if (!RESET_IN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      FRAME_VALID = 1'b0;
      CLEAR       = 1'b0;
      FRAME_DONE  = 1'b0;
      BUSY        = 1'b1;
      unique case (r_state)
         IDLE: begin
            BUSY = 1'b0;
            if (START) begin
               w_next = COLLECT;
            end
         end
         COLLECT: begin
            if (r_count == N_CNT) begin
               w_next = STREAM;
            end
         end
         STREAM: begin
            FRAME_VALID = 1'b1;
            if (DONE) begin
               w_next = CLR;
            end
         end
         CLR: begin
            CLEAR      = 1'b1;
            FRAME_DONE = 1'b1;
            w_next     = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_out_frame_ctrl.sv
// Self-checking bench for out_frame_ctrl: arbitration table, directed
// frame sequences and randomized lane traffic against a frame model.
module tb_out_frame_ctrl;

   localparam int N  = 256;
   localparam int IB = 8;
   localparam int L  = 4;

   logic              CLK_IN = 1'b0;
   logic              RESET_IN;
   logic              START;
   logic              DONE;
   logic [L-1:0]      LANE_REQ;
   logic [L*IB-1:0]   LANE_IDX;
   logic [L*16-1:0]   LANE_ACC_X;
   logic [L*16-1:0]   LANE_ACC_Y;
   logic [L-1:0]      LANE_GNT;
   logic              WR_EN;
   logic [IB-1:0]     WR_IDX;
   logic [15:0]       ACC_X;
   logic [15:0]       ACC_Y;
   logic              FRAME_VALID;
   logic              CLEAR;
   logic              BUSY;
   logic              FRAME_DONE;
   logic              ERR;

   int n_vec = 0;
   int n_bad = 0;
   int wr_pulses = 0;
   int guard;

   always #5 CLK_IN = ~CLK_IN;

   out_frame_ctrl #(
      .N         (N),
      .IDX_BITS  (IB),
      .NUM_LANES (L)
   ) dut (
      .CLK_IN      (CLK_IN),
      .RESET_IN    (RESET_IN),
      .START       (START),
      .LANE_REQ    (LANE_REQ),
      .LANE_IDX    (LANE_IDX),
      .LANE_ACC_X  (LANE_ACC_X),
      .LANE_ACC_Y  (LANE_ACC_Y),
      .LANE_GNT    (LANE_GNT),
      .WR_EN       (WR_EN),
      .WR_IDX      (WR_IDX),
      .ACC_X       (ACC_X),
      .ACC_Y       (ACC_Y),
      .FRAME_VALID (FRAME_VALID),
      .CLEAR       (CLEAR),
      .DONE        (DONE),
      .BUSY        (BUSY),
      .FRAME_DONE  (FRAME_DONE),
      .ERR         (ERR)
   );

   // Frame model: phase 0 idle, 1 collect, 2 stream, 3 clear.
   int          m_phase = 0;
   bit          m_seen[int];
   int          m_ptr = 0;
   logic        m_err = 1'b0;
   logic        m_wr = 1'b0;
   logic [7:0]  m_idx = '0;
   logic [15:0] m_ax = '0;
   logic [15:0] m_ay = '0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
   } arb_vec_t;

   arb_vec_t tv[12];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int m_grant();
      int k;
      if (m_phase != 1 || m_seen.size() >= N || RESET_IN !== 1'b1)
         return -1;
      for (int i = 0; i < L; i++) begin
         k = (m_ptr + i) % L;
         if (LANE_REQ[k] === 1'b1) return k;
      end
      return -1;
   endfunction

   function automatic logic [63:0] m_out();
      int g;
      logic [3:0] gv;
      logic fv, cl, bz;
      g  = m_grant();
      gv = '0;
      if (g >= 0) gv = 4'(1) << g;
      fv = (m_phase == 2);
      cl = (m_phase == 3);
      bz = (m_phase != 0);
      return 64'({gv, m_wr, m_idx, m_ax, m_ay, fv, cl, bz, cl, m_err});
   endfunction

   function automatic logic [63:0] dut_out();
      return 64'({LANE_GNT, WR_EN, WR_IDX, ACC_X, ACC_Y,
                  FRAME_VALID, CLEAR, BUSY, FRAME_DONE, ERR});
   endfunction

   task automatic cyc();
      int g, nxt, idx;
      @(negedge CLK_IN);
      chk("cycle", dut_out(), m_out());
      if (WR_EN === 1'b1) wr_pulses++;
      g = m_grant();
      @(posedge CLK_IN);
      if (RESET_IN !== 1'b1) begin
         m_phase = 0;
         m_seen.delete();
         m_ptr = 0;
         m_err = 1'b0;
         m_wr  = 1'b0;
         m_idx = '0;
         m_ax  = '0;
         m_ay  = '0;
      end else begin
         case (m_phase)
            0:       nxt = (START === 1'b1) ? 1 : 0;
            1:       nxt = (m_seen.size() == N) ? 2 : 1;
            2:       nxt = (DONE === 1'b1) ? 3 : 2;
            default: nxt = 0;
         endcase
         m_wr = 1'b0;
         if (g >= 0) begin
            idx   = int'(LANE_IDX[g*IB +: IB]);
            m_ptr = (g + 1) % L;
            if (idx >= N || m_seen.exists(idx)) begin
               m_err = 1'b1;
            end else begin
               m_seen[idx] = 1'b1;
               m_wr  = 1'b1;
               m_idx = 8'(idx);
               m_ax  = LANE_ACC_X[g*16 +: 16];
               m_ay  = LANE_ACC_Y[g*16 +: 16];
            end
         end
         if (m_phase == 3) m_seen.delete();
         m_phase = nxt;
      end
      #1;
   endtask

   task automatic set_lane(input int l, input int idx);
      LANE_IDX[l*IB +: IB]   = 8'(idx);
      LANE_ACC_X[l*16 +: 16] = 16'($urandom);
      LANE_ACC_Y[l*16 +: 16] = 16'($urandom);
   endtask

   task automatic do_reset();
      START    = 1'b0;
      DONE     = 1'b0;
      LANE_REQ = '0;
      RESET_IN = 1'b0;
      cyc();
      RESET_IN = 1'b1;
   endtask

   task automatic start_frame();
      START = 1'b1;
      cyc();
      START = 1'b0;
   endtask

   task automatic rand_lanes();
      int x;
      LANE_REQ = 4'($urandom);
      for (int l = 0; l < L; l++) begin
         x = $urandom_range(0, N - 1);
         if ($urandom_range(0, 3) != 0)
            for (int s = 0; s < N && m_seen.exists(x); s++)
               x = (x + 1) % N;
         set_lane(l, x);
      end
   endtask

   initial begin
      tv[0]  = '{4'b1111, 4'b0001};
      tv[1]  = '{4'b1111, 4'b0010};
      tv[2]  = '{4'b1111, 4'b0100};
      tv[3]  = '{4'b1111, 4'b1000};
      tv[4]  = '{4'b1010, 4'b0010};
      tv[5]  = '{4'b1010, 4'b1000};
      tv[6]  = '{4'b1010, 4'b0010};
      tv[7]  = '{4'b1010, 4'b1000};
      tv[8]  = '{4'b0000, 4'b0000};
      tv[9]  = '{4'b0100, 4'b0100};
      tv[10] = '{4'b0001, 4'b0001};
      tv[11] = '{4'b1001, 4'b1000};

      RESET_IN   = 1'b0;
      START      = 1'b0;
      DONE       = 1'b0;
      LANE_REQ   = '0;
      LANE_IDX   = '0;
      LANE_ACC_X = '0;
      LANE_ACC_Y = '0;
      @(posedge CLK_IN);
      #1;

      // 1: single lane fills the frame in order
      do_reset();
      chk("reset_state", dut_out(), 64'(0));
      start_frame();
      wr_pulses = 0;
      LANE_REQ  = 4'b0001;
      for (int n = 0; n < N; n++) begin
         set_lane(0, n);
         cyc();
      end
      LANE_REQ = '0;
      chk("t1_last_wr", 64'({WR_EN, WR_IDX, FRAME_VALID}),
          64'({1'b1, 8'd255, 1'b0}));
      cyc();
      chk("t1_fv", 64'(FRAME_VALID), 64'(1));
      chk("t1_pulses", 64'(wr_pulses), 64'(256));
      DONE = 1'b1;
      cyc();
      DONE = 1'b0;
      chk("t1_clr", 64'({CLEAR, FRAME_DONE, FRAME_VALID}), 64'(3'b110));
      cyc();
      chk("t1_idle", 64'({CLEAR, FRAME_DONE, BUSY}), 64'(0));

      // 2: round-robin table
      do_reset();
      start_frame();
      for (int v = 0; v < 12; v++) begin
         LANE_REQ = tv[v].req;
         for (int l = 0; l < L; l++) set_lane(l, 4 * v + l);
         #1;
         chk($sformatf("arb%0d", v), 64'(LANE_GNT), 64'(tv[v].gnt));
         cyc();
      end
      LANE_REQ = '0;

      // 3/4: duplicate index, ignored START/DONE
      do_reset();
      start_frame();
      LANE_REQ = 4'b0100;
      set_lane(2, 5);
      cyc();
      LANE_REQ = 4'b0001;
      for (int n = 0; n < 128; n++) begin
         if (n != 5) begin
            set_lane(0, n);
            cyc();
         end
      end
      LANE_REQ = '0;
      START    = 1'b1;
      DONE     = 1'b1;
      cyc();
      START = 1'b0;
      DONE  = 1'b0;
      chk("t4_collect", 64'({BUSY, FRAME_VALID, CLEAR, ERR}),
          64'(4'b1000));
      LANE_REQ = 4'b0100;
      set_lane(2, 5);
      #1;
      chk("t3_gnt", 64'(LANE_GNT), 64'(4'b0100));
      cyc();
      LANE_REQ = '0;
      chk("t3_nowr", 64'({WR_EN, ERR}), 64'(2'b01));
      LANE_REQ = 4'b0001;
      for (int n = 128; n < 255; n++) begin
         set_lane(0, n);
         cyc();
      end
      LANE_REQ = '0;
      cyc();
      cyc();
      cyc();
      chk("t3_wait", 64'({FRAME_VALID, BUSY}), 64'(2'b01));
      LANE_REQ = 4'b0001;
      set_lane(0, 255);
      cyc();
      LANE_REQ = '0;
      cyc();
      chk("t3_fv", 64'({FRAME_VALID, ERR}), 64'(2'b11));
      start_frame();
      chk("t4_stream", 64'({FRAME_VALID, CLEAR, ERR}), 64'(3'b101));
      DONE = 1'b1;
      cyc();
      DONE = 1'b0;
      cyc();
      chk("t3_end", 64'({BUSY, ERR}), 64'(2'b01));

      // 5: random traffic, reset at count 100, fresh frame
      do_reset();
      start_frame();
      guard = 0;
      while (m_seen.size() < 100 && guard < 5000) begin
         rand_lanes();
         cyc();
         guard++;
      end
      chk("t5_reach100", 64'(guard < 5000), 64'(1));
      LANE_REQ = '0;
      RESET_IN = 1'b0;
      cyc();
      RESET_IN = 1'b1;
      chk("t5_reset", dut_out(), 64'(0));
      start_frame();
      wr_pulses = 0;
      guard     = 0;
      while (m_phase != 2 && guard < 20000) begin
         rand_lanes();
         cyc();
         guard++;
      end
      LANE_REQ = '0;
      chk("t5_fv", 64'(FRAME_VALID), 64'(1));
      chk("t5_pulses", 64'(wr_pulses), 64'(256));
      DONE = 1'b1;
      cyc();
      DONE = 1'b0;
      cyc();

      // 6: back-to-back frames, START in CLR is dropped
      do_reset();
      start_frame();
      LANE_REQ = 4'b0001;
      for (int n = 0; n < N; n++) begin
         set_lane(0, n);
         cyc();
      end
      LANE_REQ = '0;
      cyc();
      DONE = 1'b1;
      cyc();
      DONE = 1'b0;
      chk("t6_clr", 64'(CLEAR), 64'(1));
      START = 1'b1;
      cyc();
      chk("t6_idle", 64'(BUSY), 64'(0));
      cyc();
      START = 1'b0;
      chk("t6_busy", 64'(BUSY), 64'(1));
      LANE_REQ = 4'b0001;
      set_lane(0, 0);
      cyc();
      LANE_REQ = '0;
      chk("t6_wr0", 64'({WR_EN, WR_IDX, ERR}),
          64'({1'b1, 8'd0, 1'b0}));
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
